ram_1r1w_wr_arbiter: RTL and testbench

//  Shares the single write port of a 1r1w async-read RAM between num_req_p requesters.
//  - Arbitration is round-robin.
//  - Handshake is valid/ready per requester.
//  - Output is a registered write command that drives the RAM write port directly.
//  - An optional post-reset sweep fills every RAM word with fill_p before requesters are served.
//  - Reads bypass this block and go straight to the RAM.

---
 rtl/ram_1r1w_wr_arbiter_if.sv | 26 ++
 rtl/ram_1r1w_wr_arbiter.sv | 116 +++++++++++
 tb/tb_ram_1r1w_wr_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_1r1w_wr_arbiter_if.sv
// Requester-side write bus of ram_1r1w_wr_arbiter: packed per-requester valid/ready,
// data and address. The master drives the requests and the slave grants them.
interface ram_1r1w_wr_arbiter_if #(
    parameter int width_p   = 8,
    parameter int depth_p   = 8,
    parameter int num_req_p = 2
);
    logic [num_req_p-1:0]                 req_valid_i;
    logic [num_req_p-1:0]                 req_ready_o;
    logic [num_req_p*width_p-1:0]         req_data_i;
    logic [num_req_p*$clog2(depth_p)-1:0] req_addr_i;

    modport master (
        output req_valid_i,
        output req_data_i,
        output req_addr_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  req_addr_i,
        output req_ready_o
    );
endinterface

// File: rtl/ram_1r1w_wr_arbiter.sv
// Round-robin arbiter that shares the write port of a 1r1w RAM between requesters.
// Define RAM_ARB_INIT_SWEEP_EN to fill every word with fill_p after reset before serving.
//
// state    | meaning
// st_sweep | writing fill_p to addr 0..depth_p-1, requesters held off
// st_run   | round-robin service of requesters, one write per cycle
module ram_1r1w_wr_arbiter #(
    parameter int                 width_p   = 8,
    parameter int                 depth_p   = 8,
    parameter int                 num_req_p = 2,
    parameter logic [width_p-1:0] fill_p    = '0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    ram_1r1w_wr_arbiter_if.slave       req,
    output logic                       ram_wr_valid_o,
    output logic [width_p-1:0]         ram_wr_data_o,
    output logic [$clog2(depth_p)-1:0] ram_wr_addr_o,
    output logic                       init_done_o
);
    localparam int aw_lp = $clog2(depth_p);
    localparam int pw_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic [pw_lp-1:0]     rr_ptr_r;
    logic [pw_lp-1:0]     grant_idx;
    logic [pw_lp-1:0]     ptr_next;
    logic                 grant_v;
    logic                 serve;
    logic [num_req_p-1:0] ready;
    logic [width_p-1:0]   sel_data;
    logic [aw_lp-1:0]     sel_addr;

`ifdef RAM_ARB_INIT_SWEEP_EN
    typedef enum logic {st_sweep, st_run} state_e;
    state_e           state_r;
    logic [aw_lp-1:0] sweep_addr_r;
    logic             init_done_r;

    assign serve       = (state_r == st_run);
    assign init_done_o = init_done_r;
`else
    assign serve       = 1'b1;
    assign init_done_o = 1'b1;
`endif

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = (int'(rr_ptr_r) + k) % num_req_p;
            if (!grant_v && req.req_valid_i[idx]) begin
                grant_v   = 1'b1;
                grant_idx = pw_lp'(idx);
            end
        end
    end

    always_comb begin
        ptr_next = '0;
        if (int'(grant_idx) != num_req_p - 1) begin
            ptr_next = grant_idx + pw_lp'(1);
        end
    end

    always_comb begin
        ready = '0;
        if (serve && grant_v && !reset_i) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign req.req_ready_o = ready;
    assign sel_data = req.req_data_i[int'(grant_idx)*width_p +: width_p];
    assign sel_addr = req.req_addr_i[int'(grant_idx)*aw_lp +: aw_lp];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ram_wr_valid_o <= 1'b0;
            ram_wr_data_o  <= '0;
            ram_wr_addr_o  <= '0;
            rr_ptr_r       <= '0;
`ifdef RAM_ARB_INIT_SWEEP_EN
            state_r        <= st_sweep;
            sweep_addr_r   <= '0;
            init_done_r    <= 1'b0;
`endif
        end else begin
`ifdef RAM_ARB_INIT_SWEEP_EN
            if (state_r == st_sweep) begin
                ram_wr_valid_o <= 1'b1;
                ram_wr_addr_o  <= sweep_addr_r;
                ram_wr_data_o  <= fill_p;
                sweep_addr_r   <= sweep_addr_r + aw_lp'(1);
                if (sweep_addr_r == aw_lp'(depth_p - 1)) begin
                    state_r     <= st_run;
                    init_done_r <= 1'b1;
                end
            end else
`endif
            begin
                if (grant_v) begin
                    ram_wr_valid_o <= 1'b1;
                    ram_wr_data_o  <= sel_data;
                    ram_wr_addr_o  <= sel_addr;
                    rr_ptr_r       <= ptr_next;
                end else begin
                    // Data and address hold so the RAM pins only toggle on real writes.
                    ram_wr_valid_o <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_1r1w_wr_arbiter.sv
// Scoreboard bench for ram_1r1w_wr_arbiter with an in-bench RAM and a reference model
// of round-robin service; covers the sweep build when RAM_ARB_INIT_SWEEP_EN is defined.
module tb_ram_1r1w_wr_arbiter;
    localparam int W = 8;
    localparam int D = 8;
    localparam int N = 2;
    localparam logic [7:0] FILL = 8'hA5;

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       ram_wr_valid_o;
    logic [7:0] ram_wr_data_o;
    logic [2:0] ram_wr_addr_o;
    logic       init_done_o;

    ram_1r1w_wr_arbiter_if #(.width_p(W), .depth_p(D), .num_req_p(N)) rif ();

    ram_1r1w_wr_arbiter #(.width_p(W), .depth_p(D), .num_req_p(N), .fill_p(FILL)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req            (rif.slave),
        .ram_wr_valid_o (ram_wr_valid_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .init_done_o    (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    int         cyc      = 0;
    logic       rst_q    = 1'b0;
    logic [7:0] ram  [D];
    logic [7:0] mref [D];
    exp_t       q [$];
    int         grant_log [$];
    logic [N-1:0] ready_s = '0;
    int         m_ptr   = 0;
    int         m_sweep = 0;
    bit         m_done  = 1'b0;
    bit         rand_en = 1'b0;
    int         rand_prob = 60;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // The RAM behind the write port, plus cycle and reset bookkeeping.
    always @(posedge clk_i) begin
        if (ram_wr_valid_o) ram[ram_wr_addr_o] <= ram_wr_data_o;
        rst_q <= reset_i;
        cyc   <= cyc + 1;
    end

    // Reference model: predicts ready and the command that must appear next cycle.
    always @(negedge clk_i) begin
        int g;
        logic [N-1:0] exp_rdy;
        if (rst_q) begin
            chk("rst_wr_valid", 32'(ram_wr_valid_o), 32'd0);
            chk("rst_wr_data",  32'(ram_wr_data_o),  32'd0);
            chk("rst_wr_addr",  32'(ram_wr_addr_o),  32'd0);
            m_ptr   = 0;
            m_sweep = 0;
`ifdef RAM_ARB_INIT_SWEEP_EN
            m_done  = 1'b0;
`else
            m_done  = 1'b1;
`endif
            q.delete();
        end
        ready_s = rif.req_ready_o;
        if (!m_done) begin
            chk("sweep_ready", 32'(rif.req_ready_o), 32'd0);
            chk("sweep_init_done", 32'(init_done_o), 32'd0);
            if (!reset_i) begin
                q.push_back('{cyc + 1, 3'(m_sweep), FILL});
                mref[m_sweep] = FILL;
            end
            m_sweep++;
            if (m_sweep == D) m_done = 1'b1;
        end else begin
            chk("init_done", 32'(init_done_o), 32'd1);
            g = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && rif.req_valid_i[idx]) g = idx;
            end
            exp_rdy = '0;
            if (g >= 0 && !reset_i) exp_rdy[g] = 1'b1;
            chk("ready", 32'(rif.req_ready_o), 32'(exp_rdy));
            if (g >= 0 && !reset_i) begin
                q.push_back('{cyc + 1, rif.req_addr_i[g*3 +: 3], rif.req_data_i[g*8 +: 8]});
                mref[rif.req_addr_i[g*3 +: 3]] = rif.req_data_i[g*8 +: 8];
                grant_log.push_back(g);
                m_ptr = (g + 1) % N;
            end
        end
    end

    // Monitor: every RAM write command must match the oldest expected one due this cycle.
    always @(negedge clk_i) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missing_cmd", 32'd0, {21'd0, e.addr, e.data});
        end
        if (ram_wr_valid_o) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("cmd_addr", 32'(ram_wr_addr_o), 32'(e.addr));
                chk("cmd_data", 32'(ram_wr_data_o), 32'(e.data));
            end else begin
                chk("unexpected_cmd", {21'd0, ram_wr_addr_o, ram_wr_data_o}, 32'hFFFF_FFFF);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        if (rand_en) begin
            for (int i = 0; i < N; i++) begin
                if (!rif.req_valid_i[i] || ready_s[i]) begin
                    if ($urandom_range(0, 99) < rand_prob) begin
                        rif.req_valid_i[i]       = 1'b1;
                        rif.req_data_i[i*8 +: 8] = 8'($urandom);
                        rif.req_addr_i[i*3 +: 3] = 3'($urandom);
                    end else begin
                        rif.req_valid_i[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        rif.req_valid_i = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic compare_ram(input string name);
        for (int a = 0; a < D; a++) chk(name, 32'(ram[a]), 32'(mref[a]));
    endtask

    initial begin
        for (int a = 0; a < D; a++) begin
            ram[a]  = 8'h00;
            mref[a] = 8'h00;
        end
        rif.req_valid_i = '0;
        rif.req_data_i  = '0;
        rif.req_addr_i  = '0;
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;

`ifdef RAM_ARB_INIT_SWEEP_EN
        // Interrupt the sweep part way, then let it run to completion.
        step(); step(); step(); step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        idle(D + 3);
        for (int a = 0; a < D; a++) chk("sweep_fill", 32'(ram[a]), 32'(FILL));
        chk("sweep_done", 32'(init_done_o), 32'd1);
`else
        chk("no_sweep_init_done", 32'(init_done_o), 32'd1);
        chk("no_sweep_wr_valid", 32'(ram_wr_valid_o), 32'd0);
        rif.req_valid_i[1]     = 1'b1;
        rif.req_addr_i[3 +: 3] = 3'd7;
        rif.req_data_i[8 +: 8] = 8'h5A;
        step();
        rif.req_valid_i = '0;
        idle(2);
        chk("req1_mem7", 32'(ram[7]), 32'h5A);
        // The req1 grant leaves the pointer at 0 again, matching the swept build.
`endif

        // Single requester 0.
        rif.req_valid_i[0]     = 1'b1;
        rif.req_addr_i[0 +: 3] = 3'd3;
        rif.req_data_i[0 +: 8] = 8'h3C;
        step();
        rif.req_valid_i = '0;
        step();
        step();
        chk("single_mem3", 32'(ram[3]), 32'h3C);

        // Contention with the pointer at 1: grants must go 1,0,1,0.
        grant_log.delete();
        rand_prob = 100;
        rand_en   = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rand_en = 1'b0;
        idle(3);
        chk("contention_len", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            chk("grant0", 32'(grant_log[0]), 32'd1);
            chk("grant1", 32'(grant_log[1]), 32'd0);
            chk("grant2", 32'(grant_log[2]), 32'd1);
            chk("grant3", 32'(grant_log[3]), 32'd0);
        end
        compare_ram("ram_after_contention");

        // Random traffic, reset in the middle of it, then more random traffic.
        rand_prob = 60;
        rand_en   = 1'b1;
        for (int i = 0; i < 150; i++) step();
        rand_en = 1'b0;
        reset_i = 1'b1;
        rif.req_valid_i = '0;
        step();
        reset_i = 1'b0;
`ifdef RAM_ARB_INIT_SWEEP_EN
        idle(D + 2);
`endif
        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) step();
        rand_en = 1'b0;
        idle(4);
        chk("queue_drained", 32'(q.size()), 32'd0);
        compare_ram("ram_final");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
